req_arbiter_ctrl: RTL and testbench
===================================

Name: req_arbiter_ctrl

Overview:
- Sequential arbiter that shares one downstream resource among 16 requesters, using the team's descending-index priority convention (highest index wins).
- Registers a winner, holds the grant until the requester releases, drops its request or hits a hold limit, then re-arbitrates after a one-cycle gap.
- Supports fixed-priority and round-robin modes.
- Reports the grant as an 8-bit code; 8'hF0 means no grant, matching the existing encoder output format.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 for this tile.
- IDX_W, 4, width of the grant index.
- MAX_HOLD, 15, maximum grant length in cycles before forced release; must be in 1..255.
- NO_GRANT, 8'hF0, code_out value when no grant is active.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ena  in  1  global enable; low freezes all state
- req  in  16  request vector; bit i = requester i
- rr_mode  in  1  0 = fixed priority (highest index wins); 1 = round-robin
- release_i  in  1  granted requester signals it is done
- grant_valid  out  1  a grant is active
- grant_idx  out  4  index of the granted requester
- grant_onehot  out  16  one-hot grant; all zeros when grant_valid=0
- code_out  out  8  {4'b0, grant_idx} when grant_valid=1, else NO_GRANT
- timeout_o  out  1  single-cycle pulse on a forced release

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values:
  - state = IDLE
  - grant_valid = 0, grant_idx = 0, grant_onehot = 0
  - code_out = 8'hF0
  - timeout_o = 0
  - hold_cnt = 0
  - rr_last = 0
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at a clk edge, pick a winner; on the next cycle grant_valid=1 and state=GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - If req == 0, stay in IDLE.
- Fixed mode winner: highest set bit of req.
- Round-robin winner:
  - Search order is rr_last-1, rr_last-2, ... modulo 16, with rr_last itself checked last.
  - rr_last updates to the winner when the grant is issued.
  - After reset, rr_last=0 gives search order 15..0, identical to fixed mode.
- GRANT:
  - hold_cnt starts at 1 in the first grant cycle and increments each cycle.
  - Grant ends, moving to GAP, on the first of:
    - release_i=1
    - req[grant_idx]=0
    - hold_cnt == MAX_HOLD with neither of the above (forced release: timeout_o pulses for 1 cycle, coincident with GAP entry)
  - A grant therefore lasts at most MAX_HOLD cycles.
- GAP:
  - Exactly one cycle with grant_valid=0 and code_out=F0, then IDLE.
  - Requests are not sampled in GAP, so the minimum spacing between grants is 2 cycles.
- Simultaneous events:
  - release_i or a request drop in the same cycle as hold_cnt == MAX_HOLD is a normal release; no timeout_o pulse.
  - release_i while in IDLE or GAP is ignored.
- rr_mode changes are sampled only at arbitration; a change mid-grant does not affect the current holder.
- ena=0: state, counters, rr_last and outputs hold their values; timeout_o is forced to 0.
- Reset mid-grant: outputs go to reset values immediately (asynchronous).
- Invariant: grant_onehot == (grant_valid ? 1<<grant_idx : 0) at all times.

Decomposition:
- Shared package (arb_pkg):
  - state enum {IDLE, GRANT, GAP}
  - NO_GRANT_CODE = 8'hF0
  - IDX_W, N_REQ constants
- Sub-module rr_pick (combinational):
  - Inputs: req[15:0], start index, mode.
  - Outputs: winner index, any-valid flag.
  - Implements both fixed and rotated highest-index search.

Test Plan:
- Fixed mode, req=16'h0021 held, release_i pulsed on the 3rd grant cycle:
  - grant_idx=5, code_out=8'h05 one cycle after req.
  - Then one GAP cycle with code_out=F0.
  - Then re-grant to idx 5.
- Round-robin, req=16'h8001 held, release_i after each grant's 1st cycle:
  - Grants alternate 15, 0, 15, 0.
  - Each grant is separated by a one-cycle GAP.
- MAX_HOLD=15, req[3] held, no release:
  - grant_valid high exactly 15 cycles.
  - timeout_o=1 for exactly 1 cycle, on the first GAP cycle.
  - Re-grant to idx 3 after GAP.
- release_i asserted in the same cycle hold_cnt reaches 15: no timeout_o pulse; normal GAP.
- Mid-grant on idx 7: deassert ena for 4 cycles, then reassert; hold_cnt resumes from its frozen value. Then assert rst_n=0 mid-grant; code_out=F0 and grant_onehot=0 immediately, without waiting for a clk edge.
- req=0 for 20 cycles after reset: grant_valid=0 and code_out=8'hF0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester arbiter tile.
package arb_pkg;

    localparam int unsigned N_REQ  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned CODE_W = 8;

    localparam logic [CODE_W-1:0] NO_GRANT_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational winner search: highest index wins, optionally rotated so the
// search starts just below i_start and checks i_start itself last.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    input  logic             i_rr_mode,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    logic [IDX_W-1:0] w_start;

    // A start of 0 gives the plain 15..0 order, so fixed mode reuses the same search.
    assign w_start = i_rr_mode ? i_start : IDX_W'(0);

    always_comb begin
        o_idx_c = '0;
        o_any_c = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            if (!o_any_c && i_req[w_start - IDX_W'(k)]) begin
                o_any_c = 1'b1;
                o_idx_c = w_start - IDX_W'(k);
            end
        end
    end

endmodule : rr_pick

// File: rtl/req_arbiter_ctrl.sv
// Sequential 16-way arbiter: registered grant, hold limit with timeout pulse,
// one-cycle gap between grants, fixed-priority or round-robin selection.
module req_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15   // 1..255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic               rr_mode,
    input  logic               release_i,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [N_REQ-1:0]   grant_onehot,
    output logic [CODE_W-1:0]  code_out,
    output logic               timeout_o
);

    arb_state_e         r_state,        w_nxt_state;
    logic               r_grant_valid,  w_nxt_grant_valid;
    logic [IDX_W-1:0]   r_grant_idx,    w_nxt_grant_idx;
    logic [N_REQ-1:0]   r_grant_onehot, w_nxt_grant_onehot;
    logic [CODE_W-1:0]  r_code,         w_nxt_code;
    logic               r_timeout,      w_nxt_timeout;
    logic [HOLD_W-1:0]  r_hold_cnt,     w_nxt_hold_cnt;
    logic [IDX_W-1:0]   r_rr_last,      w_nxt_rr_last;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_release;
    logic               w_hold_limit;

    rr_pick u_rr_pick (
        .i_req     (req),
        .i_start   (r_rr_last),
        .i_rr_mode (rr_mode),
        .o_idx_c   (w_pick_idx),
        .o_any_c   (w_pick_any)
    );

    // A voluntary release takes precedence over the hold limit, suppressing the timeout.
    assign w_release    = release_i || !req[r_grant_idx];
    assign w_hold_limit = (r_hold_cnt == HOLD_W'(MAX_HOLD));

    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_grant_valid  = r_grant_valid;
        w_nxt_grant_idx    = r_grant_idx;
        w_nxt_grant_onehot = r_grant_onehot;
        w_nxt_code         = r_code;
        w_nxt_timeout      = 1'b0;
        w_nxt_hold_cnt     = r_hold_cnt;
        w_nxt_rr_last      = r_rr_last;

        if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        w_nxt_state        = GRANT;
                        w_nxt_grant_valid  = 1'b1;
                        w_nxt_grant_idx    = w_pick_idx;
                        w_nxt_grant_onehot = N_REQ'(1) << w_pick_idx;
                        w_nxt_code         = {(CODE_W - IDX_W)'(0), w_pick_idx};
                        w_nxt_hold_cnt     = HOLD_W'(1);
                        w_nxt_rr_last      = w_pick_idx;
                    end
                end
                GRANT: begin
                    if (w_release || w_hold_limit) begin
                        w_nxt_state        = GAP;
                        w_nxt_grant_valid  = 1'b0;
                        w_nxt_grant_onehot = '0;
                        w_nxt_code         = NO_GRANT_CODE;
                        w_nxt_timeout      = !w_release;
                        w_nxt_hold_cnt     = '0;
                    end else begin
                        w_nxt_hold_cnt     = r_hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    w_nxt_state = IDLE;
                end
                default: begin
                    w_nxt_state        = IDLE;
                    w_nxt_grant_valid  = 1'b0;
                    w_nxt_grant_onehot = '0;
                    w_nxt_code         = NO_GRANT_CODE;
                    w_nxt_hold_cnt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_code         <= NO_GRANT_CODE;
            r_timeout      <= 1'b0;
            r_hold_cnt     <= '0;
            r_rr_last      <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_grant_valid  <= w_nxt_grant_valid;
            r_grant_idx    <= w_nxt_grant_idx;
            r_grant_onehot <= w_nxt_grant_onehot;
            r_code         <= w_nxt_code;
            r_timeout      <= w_nxt_timeout;
            r_hold_cnt     <= w_nxt_hold_cnt;
            r_rr_last      <= w_nxt_rr_last;
        end
    end

    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;
    assign code_out     = r_code;
    assign timeout_o    = r_timeout;

endmodule : req_arbiter_ctrl

// File: tb/tb_req_arbiter_ctrl.sv
// Directed bench for req_arbiter_ctrl with hand-computed expectations.
module tb_req_arbiter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] req;
    logic        rr_mode;
    logic        release_i;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic [7:0]  code_out;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    req_arbiter_ctrl #(.MAX_HOLD(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .req          (req),
        .rr_mode      (rr_mode),
        .release_i    (release_i),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .code_out     (code_out),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect an active grant on idx, with consistent one-hot and code.
    task automatic chk_grant(input string tag, input int idx);
        chk({tag, "_valid"},  32'(grant_valid),  32'd1);
        chk({tag, "_idx"},    32'(grant_idx),    32'(idx));
        chk({tag, "_onehot"}, 32'(grant_onehot), 32'd1 << idx);
        chk({tag, "_code"},   32'(code_out),     32'(idx));
    endtask

    task automatic chk_idle(input string tag, input logic exp_to);
        chk({tag, "_valid"},   32'(grant_valid),  32'd0);
        chk({tag, "_onehot"},  32'(grant_onehot), 32'd0);
        chk({tag, "_code"},    32'(code_out),     32'hF0);
        chk({tag, "_timeout"}, 32'(timeout_o),    32'(exp_to));
    endtask

    int exp_rr [4] = '{15, 0, 15, 0};

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req       = '0;
        rr_mode   = 1'b0;
        release_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset", 1'b0);
        chk("reset_idx", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;

        // No requests: nothing is ever granted.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("noreq_valid", 32'(grant_valid), 32'd0);
            chk("noreq_code",  32'(code_out),    32'hF0);
        end

        // Round-robin from reset state: 15, 0, 15, 0 with one-cycle gaps.
        rr_mode = 1'b1;
        req     = 16'h8001;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_grant("rr_grant", exp_rr[g]);
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            chk_idle("rr_gap", 1'b0);
            if (g == 3) req = '0;
            tick();
            chk("rr_idle_valid", 32'(grant_valid), 32'd0);
        end
        rr_mode = 1'b0;

        // Fixed priority: highest set bit wins; release on 3rd grant cycle.
        req = 16'h0021;
        tick();
        chk_grant("fx_g1", 5);
        tick();
        chk_grant("fx_g2", 5);
        tick();
        chk_grant("fx_g3", 5);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk_idle("fx_gap", 1'b0);
        tick();
        chk("fx_idle_valid", 32'(grant_valid), 32'd0);
        tick();
        chk_grant("fx_regrant", 5);
        req = '0;
        tick();
        chk_idle("fx_drop", 1'b0);
        tick();

        // Hold limit: exactly 15 grant cycles, then a one-cycle timeout pulse.
        req = 16'h0008;
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("to_valid",   32'(grant_valid), 32'd1);
            chk("to_timeout", 32'(timeout_o),   32'd0);
            tick();
        end
        chk_idle("to_gap", 1'b1);
        tick();
        chk_idle("to_idle", 1'b0);
        tick();
        chk_grant("to_regrant", 3);

        // Release coincident with the hold limit: normal release, no pulse.
        for (int i = 0; i < 14; i++) tick();
        chk_grant("rl_c15", 3);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        req       = '0;
        chk_idle("rl_gap", 1'b0);
        tick();
        chk_idle("rl_idle", 1'b0);

        // Enable freeze mid-grant on idx 7; hold count must resume, not restart.
        req = 16'h0080;
        tick();
        tick();
        tick();
        chk_grant("en_c3", 7);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_grant("en_frozen", 7);
            chk("en_frozen_to", 32'(timeout_o), 32'd0);
        end
        ena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("en_resume_valid", 32'(grant_valid), 32'd1);
        end
        tick();
        chk_idle("en_timeout", 1'b1);
        tick();
        tick();
        chk_grant("en_regrant", 7);
        tick();

        // Asynchronous reset mid-grant: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst", 1'b0);
        chk("arst_idx", 32'(grant_idx), 32'd0);
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("post_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_req_arbiter_ctrl
